// File: rtl/dct_pkg.sv
// Shared definitions for the DCT frame scheduler: FSM encodings, bank names
// and the block size.
package dct_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FULL = 3'd1,
        START     = 3'd2,
        RUN       = 3'd3,
        RELEASE   = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic BANK_A        = 1'b0;
    localparam logic BANK_B        = 1'b1;
    localparam int   BLOCK_SAMPLES = 64;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; lets a level-style completion signal be
// consumed exactly once per assertion.
module rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/dct_frame_scheduler.sv
// Frame-level scheduler for the 8x8 DCT core: ping-pong bank ownership,
// core start pulse, block coordinates and frame completion.
module dct_frame_scheduler
    import dct_pkg::*;
#(
    parameter int BLOCKS_X = 4,
    parameter int BLOCKS_Y = 4,
    parameter int CNT_W    = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Frame_Start,
    input  logic             Fill_Done,
    output logic             Fill_Ready,
    output logic             Fill_Bank,
    output logic             Core_Start,
    input  logic             Core_Ready,
    output logic             Proc_Bank,
    output logic [CNT_W-1:0] Block_X,
    output logic [CNT_W-1:0] Block_Y,
    output logic             Busy,
    output logic             Frame_Done,
    output logic             Overrun
);

    localparam int TOTAL = BLOCKS_X * BLOCKS_Y;
    localparam int FC_W  = $clog2(TOTAL + 1);
    localparam logic [FC_W-1:0]  TOTAL_C = FC_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_X  = CNT_W'(BLOCKS_X - 1);
    localparam logic [CNT_W-1:0] LAST_Y  = CNT_W'(BLOCKS_Y - 1);

    state_t            state, state_next;
    logic [1:0]        full;
    logic [FC_W-1:0]   fill_count;
    logic              proc_bank, fill_bank, overrun;
    logic [CNT_W-1:0]  block_x, block_y;
    logic              ready_rise, fill_accept, is_last;

    rise_detect u_ready_rise (
        .Clock (Clock),
        .Reset (Reset),
        .din   (Core_Ready),
        .rise  (ready_rise)
    );

    assign Busy        = (state != IDLE);
    assign Fill_Ready  = Busy && !full[fill_bank] && (fill_count < TOTAL_C);
    assign fill_accept = Fill_Done && Fill_Ready;
    assign is_last     = (block_x == LAST_X) && (block_y == LAST_Y);

    assign Fill_Bank = fill_bank;
    assign Proc_Bank = proc_bank;
    assign Block_X   = block_x;
    assign Block_Y   = block_y;
    assign Overrun   = overrun;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Core_Start = 1'b0;
        Frame_Done = 1'b0;
        case (state)
            IDLE:      if (Frame_Start) state_next = WAIT_FULL;
            WAIT_FULL: if (full[proc_bank]) state_next = START;
            START: begin
                Core_Start = 1'b1;
                state_next = RUN;
            end
            RUN:       if (ready_rise) state_next = RELEASE;
            RELEASE:   state_next = is_last ? DONE : WAIT_FULL;
            DONE: begin
                Frame_Done = 1'b1;
                state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    // Fill-side set and release-side clear never hit the same bank in one
    // cycle, because Fill_Ready is low whenever Fill_Bank's bank is still full.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            full       <= 2'b00;
            fill_count <= '0;
            proc_bank  <= BANK_A;
            fill_bank  <= BANK_A;
            overrun    <= 1'b0;
            block_x    <= '0;
            block_y    <= '0;
        end else if (state == IDLE) begin
            if (Frame_Start) begin
                full       <= 2'b00;
                fill_count <= '0;
                proc_bank  <= BANK_A;
                fill_bank  <= BANK_A;
                overrun    <= 1'b0;
                block_x    <= '0;
                block_y    <= '0;
            end
        end else begin
            // Loader pulses outside a frame are not overruns: no bank is on offer.
            if (fill_accept) begin
                full[fill_bank] <= 1'b1;
                fill_bank       <= ~fill_bank;
                fill_count      <= fill_count + 1'b1;
            end else if (Fill_Done) begin
                overrun <= 1'b1;
            end
            if (state == RELEASE) begin
                full[proc_bank] <= 1'b0;
                proc_bank       <= ~proc_bank;
                if (!is_last) begin
                    if (block_x == LAST_X) begin
                        block_x <= '0;
                        block_y <= block_y + 1'b1;
                    end else begin
                        block_x <= block_x + 1'b1;
                    end
                end
            end
        end
    end

endmodule
